// File: rtl/mux_sel_arbiter_if.sv
// rtl/mux_sel_arbiter_if.sv - handshake bundle between two packet sources, the arbiter and the output sink
//
// Ports (signals):
//    din_0_valid/data/last, din_0_ready : source 0 beat stream
//    din_1_valid/data/last, din_1_ready : source 1 beat stream
//    out_valid/data/last, out_ready     : registered output stream
//    sel                                : select for the downstream 2:1 mux
//    busy                               : packet grant held
// Modports: slave = arbiter side, master = sources/sink side.
interface mux_sel_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             din_0_valid;
   logic [WIDTH-1:0] din_0_data;
   logic             din_0_last;
   logic             din_0_ready;
   logic             din_1_valid;
   logic [WIDTH-1:0] din_1_data;
   logic             din_1_last;
   logic             din_1_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             out_ready;
   logic             sel;
   logic             busy;

   modport slave (
      input  din_0_valid, din_0_data, din_0_last,
      output din_0_ready,
      input  din_1_valid, din_1_data, din_1_last,
      output din_1_ready,
      output out_valid, out_data, out_last,
      input  out_ready,
      output sel, busy
   );

   modport master (
      output din_0_valid, din_0_data, din_0_last,
      input  din_0_ready,
      output din_1_valid, din_1_data, din_1_last,
      input  din_1_ready,
      input  out_valid, out_data, out_last,
      output out_ready,
      input  sel, busy
   );
endinterface

// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - packet-locked round-robin arbiter driving a 2:1 mux select
//
// Ports:
//    clk   : system clock, rising edge
//    rst_n : asynchronous active-low reset
//    bus   : mux_sel_arbiter_if.slave (two input streams, registered output
//            stream, sel, busy)
// A grant is held for a whole packet (until an accepted beat with last=1).
// Arbitration takes one IDLE cycle, so packets are separated by one bubble.
module mux_sel_arbiter #(
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst_n,
   mux_sel_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_0 = 2'd1,
      LOCK_1 = 2'd2
   } state_t;

   state_t state;
   logic   last_grant;
   logic   load_en;
   logic   acc_0;
   logic   acc_1;

   // Output register can take a beat when empty or being drained this cycle.
   // out_ready -> din_x_ready is the only combinational input-to-output path.
   assign load_en         = !bus.out_valid | bus.out_ready;
   assign bus.din_0_ready = (state == LOCK_0) & load_en;
   assign bus.din_1_ready = (state == LOCK_1) & load_en;
   assign acc_0           = bus.din_0_ready & bus.din_0_valid;
   assign acc_1           = bus.din_1_ready & bus.din_1_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         bus.sel       <= 1'b0;
         bus.busy      <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= {WIDTH{1'b0}};
         bus.out_last  <= 1'b0;
      end else begin
         // Output stage: load on accept, otherwise drain; data/last hold
         // their last value after draining.
         if (acc_0) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.din_0_data;
            bus.out_last  <= bus.din_0_last;
         end else if (acc_1) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.din_1_data;
            bus.out_last  <= bus.din_1_last;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               // On a tie the source that did not win last time is granted.
               if (bus.din_0_valid && (!bus.din_1_valid || last_grant)) begin
                  state      <= LOCK_0;
                  bus.sel    <= 1'b0;
                  last_grant <= 1'b0;
                  bus.busy   <= 1'b1;
               end else if (bus.din_1_valid) begin
                  state      <= LOCK_1;
                  bus.sel    <= 1'b1;
                  last_grant <= 1'b1;
                  bus.busy   <= 1'b1;
               end
            end
            LOCK_0: begin
               if (acc_0 && bus.din_0_last) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
            LOCK_1: begin
               if (acc_1 && bus.din_1_last) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule
